multi_voice_sound_gen: RTL and testbench
========================================

# multi_voice_sound_gen

Parametrised multi-voice sound generator, the successor to the single-voice complex sound generator. It provides NCH independent voices. Each voice is a square-wave or LFSR-noise oscillator with optional shared-LFO frequency modulation, a per-voice volume and an optional one-shot decay envelope. Voices are summed into an unsigned PCM word for the audio DAC/PWM stage; a legacy 1-bit AND-mix output is retained.

## Interface
- NCH, 4: number of voices (1..16)
- FREQ_W, 12: voice period width
- LFO_W, 10: LFO period width (LFO_W+8 >= FREQ_W)
- VOL_W, 4: volume/envelope level width
- PRESCALE, 16: clocks per tick (>= 2)
- OUT_W, VOL_W+$clog2(NCH): pcm_out width (derived, do not override)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- freq  in  NCH*FREQ_W  voice half-period reload values, voice i at [i*FREQ_W +: FREQ_W]
- mode  in  NCH  1 = noise voice, 0 = square voice
- lfo_mod  in  NCH  1 = LFO modulates this voice's period
- lfo_freq  in  LFO_W  LFO half-period, in units of 256 ticks
- lfo_shift  in  3  modulation depth (right shift of the triangle)
- enable  in  NCH  voice enters both mixers
- volume  in  NCH*VOL_W  static level, or envelope start level
- env_mode  in  NCH  1 = level comes from the envelope
- env_rate  in  8  envelope step period minus one, in ticks
- trig  in  NCH  one-clock envelope trigger pulses (sampled on every clock)
- pcm_out  out  OUT_W  registered sum of active voice levels
- signal_out  out  1  registered AND-mix of enabled voice states
- tick  out  1  prescaler strobe (combinational, div == 0)

## Operation
- Prescaler: div counts 0..PRESCALE-1 and wraps. tick = (div == 0). All oscillator, LFO, envelope-step and mixer updates occur only on tick edges.
- LFO: counter of LFO_W+8 bits.
  - On a tick: if it is 0, reload {lfo_freq, 8'b0}; else decrement.
  - t = top FREQ_W bits of the counter, bitwise-inverted when the MSB is set.
  - delta = t >> lfo_shift.
- Voice i: counter of FREQ_W+1 bits, so no overflow is possible. On a tick:
  - If count == 0: reload freq_i + (lfo_mod_i ? delta : 0), and update state.
    - Square voice: state toggles.
    - Noise voice: state toggles only if lfsr[i mod 16] == 1.
  - Otherwise: decrement.
  - Square half-period is (reload+1) ticks.
- LFSR: 16-bit Galois, right shift, taps 16'hB400, reset value 16'h0001. Advances every tick. Maximal period 65535.
- Envelope, per voice, with level env_i (VOL_W bits) and step divider ediv_i (8 bits):
  - trig_i on any clock: env_i <= volume_i, ediv_i <= 0. trig has priority over a same-clock step.
  - Else, on a tick with env_i != 0: if ediv_i == env_rate, decrement env_i and clear ediv_i; else increment ediv_i.
  - env_i saturates at 0 and holds until the next trig.
- Level: lvl_i = env_mode_i ? env_i : volume_i.
- Mixers, registered on tick from the pre-update (old) states:
  - pcm_out = sum over i of (enable_i & state_i) ? lvl_i : 0. Width OUT_W; cannot overflow.
  - signal_out = AND over i of (state_i | ~enable_i). All voices disabled gives 1.
- Input changes to freq, volume, lfo_* take effect at the next reload or tick only; there are no glitches mid-period.

## Timing
- Reset (asynchronous): div, all counters, states, env, ediv, pcm_out and signal_out go to 0; lfsr goes to 1. Outputs read 0 with no clock edge required.
- First clock edge after reset release is a tick. Every counter is 0 at that point, so every voice reloads and toggles to 1. The mixers use the old 0 states.
- Mixer latency: a state change at tick k appears on pcm_out and signal_out at tick k+1.
- Square voice period = 2*(freq+1)*PRESCALE clocks when unmodulated.
- freq = 0: a square voice toggles on every tick.
- lfo_freq = 0: LFO reloads to 0 every tick, so delta = 0.
- trig held high for several clocks: the envelope stays at volume_i; decay starts on the first tick after trig falls.

## Test plan
- NCH=4, PRESCALE=16, voice 0 square, freq=3, volume=10, env_mode=0, only voice 0 enabled -> steady state: pcm_out alternates 10/0 every 64 clocks; signal_out follows at 0/1 with 128-clock period.
- Voice 0 with lfo_mod=1, lfo_freq=10'h200, lfo_shift=7, freq=5 -> during the first 64 ticks after the LFO reload, delta=15 and voice 0 half-period = 21 ticks.
- env_mode=1, volume=8, env_rate=3, single trig pulse, voice state held high (freq max) -> pcm_out steps 8,7,...,0, one step per 4 ticks, reaching 0 after 32 ticks and holding.
- All 4 voices square, freq=0, volume=15, enabled -> pcm_out alternates 60/0 each tick; there is no wrap at OUT_W=6.
- Voice 1 noise, freq=0 -> state toggle pattern equals lfsr bit 1 per tick; lfsr returns to 16'h0001 after 65535 ticks.
- Assert reset mid-operation between clock edges -> pcm_out=0 and signal_out=0 immediately. After release, the first edge is a tick and the sequence restarts identically to power-up.

Source files
------------

// File: rtl/multi_voice_sound_gen.sv
// rtl/multi_voice_sound_gen.sv - NCH-voice square/noise generator with shared LFO, envelopes and PCM/AND mixers
module multi_voice_sound_gen #(
    parameter int NCH      = 4,
    parameter int FREQ_W   = 12,
    parameter int LFO_W    = 10,
    parameter int VOL_W    = 4,
    parameter int PRESCALE = 16,
    parameter int OUT_W    = VOL_W + $clog2(NCH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NCH*FREQ_W-1:0]   freq,
    input  logic [NCH-1:0]          mode,
    input  logic [NCH-1:0]          lfo_mod,
    input  logic [LFO_W-1:0]        lfo_freq,
    input  logic [2:0]              lfo_shift,
    input  logic [NCH-1:0]          enable,
    input  logic [NCH*VOL_W-1:0]    volume,
    input  logic [NCH-1:0]          env_mode,
    input  logic [7:0]              env_rate,
    input  logic [NCH-1:0]          trig,
    output logic [OUT_W-1:0]        pcm_out,
    output logic                    signal_out,
    output logic                    tick
);

    localparam int DIV_W = $clog2(PRESCALE);
    localparam int LC_W  = LFO_W + 8;

    logic [DIV_W-1:0]  div_q, div_d;
    logic [LC_W-1:0]   lfo_q, lfo_d;
    logic [FREQ_W-1:0] lfo_t, delta;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [FREQ_W:0]   cnt_q [NCH];
    logic [FREQ_W:0]   cnt_d [NCH];
    logic [NCH-1:0]    state_q, state_d;
    logic [VOL_W-1:0]  env_q [NCH];
    logic [VOL_W-1:0]  env_d [NCH];
    logic [7:0]        ediv_q [NCH];
    logic [7:0]        ediv_d [NCH];
    logic [OUT_W-1:0]  pcm_q, pcm_d;
    logic              sig_q, sig_d;

    assign tick       = (div_q == '0);
    assign pcm_out    = pcm_q;
    assign signal_out = sig_q;

    // Triangle: falling counter, upper half folded so t ramps up then down.
    assign lfo_t = lfo_q[LC_W-1 -: FREQ_W] ^ {FREQ_W{lfo_q[LC_W-1]}};
    assign delta = lfo_t >> lfo_shift;

    always_comb begin
        div_d  = (div_q == DIV_W'(PRESCALE - 1)) ? '0 : div_q + 1'b1;
        lfo_d  = lfo_q;
        lfsr_d = lfsr_q;
        if (tick) begin
            lfo_d  = (lfo_q == '0) ? {lfo_freq, 8'b0} : lfo_q - 1'b1;
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    always_comb begin : voices
        logic [FREQ_W-1:0] mod_add;
        logic [VOL_W-1:0]  lvl;
        logic [OUT_W-1:0]  sum;
        logic              all_hi;
        mod_add = '0;
        lvl     = '0;
        sum     = '0;
        all_hi  = 1'b1;
        state_d = state_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i]  = cnt_q[i];
            env_d[i]  = env_q[i];
            ediv_d[i] = ediv_q[i];
            mod_add   = lfo_mod[i] ? delta : '0;
            if (tick) begin
                if (cnt_q[i] == '0) begin
                    cnt_d[i] = {1'b0, freq[i*FREQ_W +: FREQ_W]} + {1'b0, mod_add};
                    if (!mode[i] || lfsr_q[4'(i % 16)])
                        state_d[i] = ~state_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] - 1'b1;
                end
            end
            if (trig[i]) begin
                env_d[i]  = volume[i*VOL_W +: VOL_W];
                ediv_d[i] = '0;
            end else if (tick && env_q[i] != '0) begin
                if (ediv_q[i] == env_rate) begin
                    env_d[i]  = env_q[i] - 1'b1;
                    ediv_d[i] = '0;
                end else begin
                    ediv_d[i] = ediv_q[i] + 1'b1;
                end
            end
            lvl = env_mode[i] ? env_q[i] : volume[i*VOL_W +: VOL_W];
            if (enable[i] && state_q[i])
                sum = sum + OUT_W'(lvl);
            if (enable[i] && !state_q[i])
                all_hi = 1'b0;
        end
        pcm_d = tick ? sum : pcm_q;
        sig_d = tick ? all_hi : sig_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q   <= '0;
            lfo_q   <= '0;
            lfsr_q  <= 16'h0001;
            state_q <= '0;
            pcm_q   <= '0;
            sig_q   <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]  <= '0;
                env_q[i]  <= '0;
                ediv_q[i] <= '0;
            end
        end else begin
            div_q   <= div_d;
            lfo_q   <= lfo_d;
            lfsr_q  <= lfsr_d;
            state_q <= state_d;
            pcm_q   <= pcm_d;
            sig_q   <= sig_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                env_q[i]  <= env_d[i];
                ediv_q[i] <= ediv_d[i];
            end
        end
    end

endmodule

// File: tb/tb_multi_voice_sound_gen.sv
// tb/tb_multi_voice_sound_gen.sv - directed table and sequence bench for multi_voice_sound_gen
module tb_multi_voice_sound_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [47:0] freq = '0;
    logic [3:0]  mode = '0;
    logic [3:0]  lfo_mod = '0;
    logic [9:0]  lfo_freq = '0;
    logic [2:0]  lfo_shift = '0;
    logic [3:0]  enable = '0;
    logic [15:0] volume = '0;
    logic [3:0]  env_mode = '0;
    logic [7:0]  env_rate = '0;
    logic [3:0]  trig = '0;
    logic [5:0]  pcm_out;
    logic        signal_out;
    logic        tick;

    int n_pass = 0;
    int n_total = 0;
    int cur = 0;

    always #5 clk = ~clk;

    multi_voice_sound_gen dut (
        .clk(clk), .reset(reset), .freq(freq), .mode(mode), .lfo_mod(lfo_mod),
        .lfo_freq(lfo_freq), .lfo_shift(lfo_shift), .enable(enable), .volume(volume),
        .env_mode(env_mode), .env_rate(env_rate), .trig(trig),
        .pcm_out(pcm_out), .signal_out(signal_out), .tick(tick)
    );

    typedef struct {
        string       name;
        logic [47:0] freq;
        logic [3:0]  mode;
        logic [3:0]  en;
        logic [15:0] vol;
        int          tk;
        int          pcm;
        int          sig;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic defaults();
        freq = '0; mode = '0; lfo_mod = '0; lfo_freq = '0; lfo_shift = '0;
        enable = '0; volume = '0; env_mode = '0; env_rate = '0; trig = '0;
    endtask

    // Reset released on a falling edge: the next rising edge is tick 0.
    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cur = 0;
    endtask

    // Return on the falling edge just after the rising edge of tick k.
    task automatic advance_to(input int k);
        int target;
        target = 16 * k + 1;
        while (cur < target) begin
            @(posedge clk);
            cur++;
        end
        @(negedge clk);
    endtask

    initial begin
        int s;
        logic [15:0] m;
        int expv;

        #1;
        check("reset_pcm", 32'(pcm_out), 0);
        check("reset_sig", 32'(signal_out), 0);
        check("reset_tick", 32'(tick), 1);

        vecs.push_back('{"sq_t0",    48'h3,            4'b0000, 4'b0001, 16'h000A, 0,  0,  0});
        vecs.push_back('{"sq_t1",    48'h3,            4'b0000, 4'b0001, 16'h000A, 1,  10, 1});
        vecs.push_back('{"sq_t4",    48'h3,            4'b0000, 4'b0001, 16'h000A, 4,  10, 1});
        vecs.push_back('{"sq_t5",    48'h3,            4'b0000, 4'b0001, 16'h000A, 5,  0,  0});
        vecs.push_back('{"sq_t9",    48'h3,            4'b0000, 4'b0001, 16'h000A, 9,  10, 1});
        vecs.push_back('{"all_t1",   48'h0,            4'b0000, 4'b1111, 16'hFFFF, 1,  60, 1});
        vecs.push_back('{"all_t2",   48'h0,            4'b0000, 4'b1111, 16'hFFFF, 2,  0,  0});
        vecs.push_back('{"all_t3",   48'h0,            4'b0000, 4'b1111, 16'hFFFF, 3,  60, 1});
        vecs.push_back('{"none_t0",  48'h0,            4'b0000, 4'b0000, 16'hFFFF, 0,  0,  1});
        vecs.push_back('{"mixvol",   48'h0,            4'b0000, 4'b0101, 16'h1248, 1,  10, 1});
        vecs.push_back('{"two_t2",   48'h000000001000, 4'b0000, 4'b0011, 16'h0021, 2,  2,  0});
        vecs.push_back('{"two_t3",   48'h000000001000, 4'b0000, 4'b0011, 16'h0021, 3,  1,  0});
        vecs.push_back('{"two_t5",   48'h000000001000, 4'b0000, 4'b0011, 16'h0021, 5,  3,  1});
        vecs.push_back('{"noise_10", 48'h0,            4'b0010, 4'b0010, 16'h0050, 10, 0,  0});
        vecs.push_back('{"noise_11", 48'h0,            4'b0010, 4'b0010, 16'h0050, 11, 5,  1});
        vecs.push_back('{"noise_13", 48'h0,            4'b0010, 4'b0010, 16'h0050, 13, 0,  0});

        foreach (vecs[i]) begin
            defaults();
            freq = vecs[i].freq; mode = vecs[i].mode;
            enable = vecs[i].en; volume = vecs[i].vol;
            do_reset();
            advance_to(vecs[i].tk);
            check($sformatf("%s_pcm", vecs[i].name), 32'(pcm_out), vecs[i].pcm);
            check($sformatf("%s_sig", vecs[i].name), 32'(signal_out), vecs[i].sig);
        end

        // Asynchronous reset between edges, then an identical restart.
        defaults();
        enable = 4'b1111; volume = 16'hFFFF;
        do_reset();
        advance_to(3);
        check("pre_rst_pcm", 32'(pcm_out), 60);
        #2 reset = 1'b1;
        #1;
        check("async_rst_pcm", 32'(pcm_out), 0);
        check("async_rst_sig", 32'(signal_out), 0);
        @(negedge clk);
        reset = 1'b0;
        cur = 0;
        advance_to(0);
        check("restart_t0_pcm", 32'(pcm_out), 0);
        advance_to(1);
        check("restart_t1_pcm", 32'(pcm_out), 60);
        check("restart_t1_sig", 32'(signal_out), 1);
        advance_to(2);
        check("restart_t2_pcm", 32'(pcm_out), 0);

        // LFO-modulated voice: reload 5 at tick 0 (delta 0), then 5+15=20.
        defaults();
        freq = 48'h5; lfo_mod = 4'b0001; lfo_freq = 10'h200; lfo_shift = 3'd7;
        enable = 4'b0001; volume = 16'h000A;
        do_reset();
        advance_to(6);
        check("lfo_t6", 32'(pcm_out), 10);
        advance_to(7);
        check("lfo_t7", 32'(pcm_out), 0);
        advance_to(27);
        check("lfo_t27", 32'(pcm_out), 0);
        advance_to(28);
        check("lfo_t28", 32'(pcm_out), 10);

        // One-shot envelope: 8 levels, one step every env_rate+1 = 4 ticks.
        defaults();
        freq = 48'hFFF; env_mode = 4'b0001; volume = 16'h0008; env_rate = 8'd3;
        enable = 4'b0001;
        do_reset();
        advance_to(1);
        check("env_pre_trig", 32'(pcm_out), 0);
        trig = 4'b0001;
        @(negedge clk);
        cur++;
        trig = 4'b0000;
        for (int k = 2; k <= 40; k++) begin
            advance_to(k);
            expv = 8 - (k - 2) / 4;
            if (expv < 0) expv = 0;
            check($sformatf("env_t%0d", k), 32'(pcm_out), expv);
        end

        // Noise voice 1 against an independent Galois LFSR model.
        defaults();
        mode = 4'b0010; enable = 4'b0010; volume = 16'h0050;
        do_reset();
        s = 0;
        m = 16'h0001;
        for (int k = 0; k < 120; k++) begin
            advance_to(k);
            check($sformatf("noise_t%0d", k), 32'(pcm_out), (s != 0) ? 5 : 0);
            if (m[1]) s = 1 - s;
            m = {1'b0, m[15:1]} ^ (m[0] ? 16'hB400 : 16'h0000);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
